// File: rtl/fx_pkg.sv
// Shared constants for the smart_ram effect scheduler: FSM encoding and
// default geometry of the sample path and RAM offset.
package fx_pkg;

    localparam int DEF_N_FX    = 2;
    localparam int DEF_ADDR_W  = 13;
    localparam int DEF_DATA_W  = 16;
    localparam int DEF_TIMEOUT = 1023;

    localparam int ST_W = 3;

    localparam logic [ST_W-1:0] ST_IDLE    = 3'd0;
    localparam logic [ST_W-1:0] ST_WR_REQ  = 3'd1;
    localparam logic [ST_W-1:0] ST_WR_WAIT = 3'd2;
    localparam logic [ST_W-1:0] ST_SCAN    = 3'd3;
    localparam logic [ST_W-1:0] ST_GRANT   = 3'd4;
    localparam logic [ST_W-1:0] ST_OUTPUT  = 3'd5;

endpackage

// File: rtl/sram_effect_scheduler_edge_detect.sv
// Registered rising-edge detector: a level that is already high when observation
// starts does not count until it falls and rises again.
module edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);

    logic d_p1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_p1 <= 1'b0;
        end else begin
            d_p1 <= d;
        end
    end

    assign rise = d & ~d_p1;

endmodule

// File: rtl/sram_effect_scheduler.sv
// Per-sample sequencer for the shared smart_ram delay buffer: writes each sample,
// then hands the RAM to every enabled effect in index order and emits the result.
module sram_effect_scheduler
    import fx_pkg::*;
#(
    parameter int N_FX    = DEF_N_FX,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sample_valid,
    input  logic [DATA_W-1:0]        sample_in,
    input  logic [N_FX-1:0]          fx_enable,
    output logic [N_FX-1:0]          fx_my_turn,
    input  logic [N_FX-1:0]          fx_done,
    input  logic [N_FX-1:0]          fx_sram_rd,
    input  logic [N_FX*ADDR_W-1:0]   fx_sram_offset,
    input  logic [N_FX*DATA_W-1:0]   fx_data_out,
    output logic [DATA_W-1:0]        sram_data_in,
    output logic [ADDR_W-1:0]        sram_offset,
    output logic                     sram_wr,
    output logic                     sram_rd,
    input  logic                     sram_write_finish,
    input  logic                     sram_read_finish,
    input  logic                     sram_available,
    output logic [DATA_W-1:0]        sample_out,
    output logic                     sample_out_valid,
    output logic                     busy,
    output logic                     overrun,
    output logic [N_FX-1:0]          fx_timeout
);

    localparam int IDX_W = $clog2(N_FX + 1);
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    logic [ST_W-1:0]   state;
    logic [IDX_W-1:0]  idx;
    logic [TMR_W-1:0]  timer;
    logic [N_FX-1:0]   en_l;
    logic [DATA_W-1:0] acc;

    logic [N_FX-1:0]   done_rise;
    logic              wf_rise;

    logic              sel_en;
    logic              sel_rise;
    logic              sel_rd;
    logic [ADDR_W-1:0] sel_off;
    logic [DATA_W-1:0] sel_data;
    logic [N_FX-1:0]   idx_mask;
    logic              grant_active;
    logic              scan_end;
    logic              timer_exp;

    // Read completion is informational only; nothing in the sequence waits on it.
    logic unused_status;
    assign unused_status = sram_read_finish;

    for (genvar g = 0; g < N_FX; g++) begin : g_done_edge
        edge_detect u_done_edge (
            .clk  (clk),
            .rst  (rst),
            .d    (fx_done[g]),
            .rise (done_rise[g])
        );
    end

    edge_detect u_wf_edge (
        .clk  (clk),
        .rst  (rst),
        .d    (sram_write_finish),
        .rise (wf_rise)
    );

    // Select the requester addressed by idx; idx == N_FX selects nothing.
    always_comb begin
        sel_en   = 1'b0;
        sel_rise = 1'b0;
        sel_rd   = 1'b0;
        sel_off  = '0;
        sel_data = '0;
        idx_mask = '0;
        for (int i = 0; i < N_FX; i++) begin
            if (idx == IDX_W'(i)) begin
                idx_mask[i] = 1'b1;
                sel_en      = en_l[i];
                sel_rise    = done_rise[i];
                sel_rd      = fx_sram_rd[i];
                sel_off     = fx_sram_offset[i*ADDR_W +: ADDR_W];
                sel_data    = fx_data_out[i*DATA_W +: DATA_W];
            end
        end
    end

    assign grant_active = (state == ST_GRANT);
    assign scan_end     = (idx == IDX_W'(N_FX));
    assign timer_exp    = (timer == TMR_W'(TIMEOUT - 1));

    // The write cycles never overlap GRANT, so wr and rd are mutually exclusive.
    assign sram_rd     = grant_active & sel_rd;
    assign sram_offset = grant_active ? sel_off : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= ST_IDLE;
            idx              <= '0;
            timer            <= '0;
            en_l             <= '0;
            fx_my_turn       <= '0;
            sram_wr          <= 1'b0;
            sram_data_in     <= '0;
            sample_out       <= '0;
            sample_out_valid <= 1'b0;
            busy             <= 1'b0;
            overrun          <= 1'b0;
            fx_timeout       <= '0;
        end else begin
            sample_out_valid <= 1'b0;
            if (sample_valid && (state != ST_IDLE)) begin
                overrun <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (sample_valid) begin
                        en_l  <= fx_enable;
                        busy  <= 1'b1;
                        state <= ST_WR_REQ;
                    end
                end

                ST_WR_REQ: begin
                    if (sram_available) begin
                        sram_wr      <= 1'b1;
                        sram_data_in <= acc;
                        state        <= ST_WR_WAIT;
                    end
                end

                ST_WR_WAIT: begin
                    if (wf_rise) begin
                        sram_wr <= 1'b0;
                        idx     <= '0;
                        state   <= ST_SCAN;
                    end
                end

                ST_SCAN: begin
                    if (scan_end) begin
                        state <= ST_OUTPUT;
                    end else if (!sel_en) begin
                        idx <= idx + 1'b1;
                    end else begin
                        timer      <= '0;
                        fx_my_turn <= idx_mask;
                        state      <= ST_GRANT;
                    end
                end

                ST_GRANT: begin
                    // A done edge in the expiry cycle still counts as completion.
                    if (sel_rise) begin
                        fx_my_turn <= '0;
                        idx        <= idx + 1'b1;
                        state      <= ST_SCAN;
                    end else if (timer_exp) begin
                        fx_timeout <= fx_timeout | idx_mask;
                        fx_my_turn <= '0;
                        idx        <= idx + 1'b1;
                        state      <= ST_SCAN;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                ST_OUTPUT: begin
                    sample_out       <= acc;
                    sample_out_valid <= 1'b1;
                    busy             <= 1'b0;
                    state            <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Sample accumulator: carries the sample through the effect chain.
    always_ff @(posedge clk) begin
        if ((state == ST_IDLE) && sample_valid) begin
            acc <= sample_in;
        end else if (grant_active && sel_rise) begin
            acc <= sel_data;
        end
    end

endmodule

// File: doc/sram_effect_scheduler.md
Name: sram_effect_scheduler

Overview:
- Per-audio-sample sequencer and arbiter for the shared smart_ram delay buffer.
- On each incoming sample it writes the sample into smart_ram, then grants the RAM to each enabled effect in index order through the my_turn/done handshake. It muxes the granted effect's rd/offset onto the RAM port and emits the final processed sample.
- Sits between codec sample path, smart_ram and the effect blocks (vibrato etc.); replaces ad-hoc bench/top-level muxing.

Parameters:
- N_FX, 2, number of effect requesters (1..8).
- ADDR_W, 13, smart_ram offset width.
- DATA_W, 16, sample width.
- TIMEOUT, 1023, max cycles an effect may hold the grant before forced revoke.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- sample_valid  in  1  one-cycle strobe, new sample on sample_in.
- sample_in  in  DATA_W  incoming audio sample.
- fx_enable  in  N_FX  per-effect enable, sampled at start of each sample.
- fx_my_turn  out  N_FX  one-hot grant to effect i.
- fx_done  in  N_FX  effect i finished (level or pulse; rising edge used).
- fx_sram_rd  in  N_FX  effect i read request.
- fx_sram_offset  in  N_FX*ADDR_W  effect i read offset, slice i = [i*ADDR_W +: ADDR_W].
- fx_data_out  in  N_FX*DATA_W  effect i result, same slicing.
- sram_data_in  out  DATA_W  write data to smart_ram.
- sram_offset  out  ADDR_W  offset to smart_ram.
- sram_wr  out  1  write request.
- sram_rd  out  1  read request.
- sram_write_finish  in  1  smart_ram write complete.
- sram_read_finish  in  1  smart_ram read complete (observed for status only).
- sram_available  in  1  smart_ram ready for new request.
- sample_out  out  DATA_W  processed sample.
- sample_out_valid  out  1  one-cycle strobe with sample_out.
- busy  out  1  high from accepted sample_valid until sample_out_valid.
- overrun  out  1  sticky; sample_valid arrived while busy.
- fx_timeout  out  N_FX  sticky per-effect timeout flag.

Behaviour:
- Reset (async): state IDLE; all outputs 0; sticky flags cleared; latched enables 0.
- States: IDLE, WR_REQ, WR_WAIT, SCAN, GRANT, OUTPUT.
- IDLE: on sample_valid, latch sample_in into acc and fx_enable into en_l, set busy, go WR_REQ.
- WR_REQ: wait for sram_available=1, then drive sram_wr=1, sram_offset=0, sram_data_in=sample; go WR_WAIT.
- WR_WAIT: hold sram_wr=1 until rising edge of sram_write_finish, then drop sram_wr next cycle. Set idx=0 and go SCAN.
- SCAN: if idx==N_FX go OUTPUT. If en_l[idx]=0, increment idx (one cycle per skipped effect). Otherwise clear timer and go GRANT.
- GRANT: fx_my_turn[idx]=1 (registered). sram_rd/sram_offset = fx_sram_rd[idx]/slice idx combinationally; they are 0 when no grant is active.
- GRANT, done: on rising edge of fx_done[idx], acc <= fx_data_out slice idx, drop my_turn next cycle, idx++, go SCAN.
- GRANT, timeout: if timer reaches TIMEOUT first, set fx_timeout[idx], keep acc, drop grant, idx++, go SCAN.
- OUTPUT: sample_out <= acc, sample_out_valid=1 for exactly one cycle, busy=0, go IDLE. sample_out holds until next OUTPUT.
- No effect enabled: sample_out = sample_in (passthrough).
- Latency, no effects: wait for available, plus write completion, plus N_FX+2 cycles.
- Edge detection: fx_done and sram_write_finish are registered once; the rising edge is detected against that registered copy. A done already high at grant start is ignored until it falls and rises again.
- Simultaneous events:
  - sample_valid in the OUTPUT cycle counts as busy: overrun set, sample dropped.
  - sample_valid in IDLE is accepted.
  - fx_done in the same cycle as timeout expiry: done wins.
- fx_enable changes mid-sample have no effect until the next sample.
- sram_wr and sram_rd are never high together; at most one fx_my_turn bit is high.
- rst asserted mid-grant: grant and RAM requests drop immediately (async); partial sample is discarded.

Decomposition:
- Shared package fx_pkg: state encoding constants, DATA_W/ADDR_W defaults, TIMEOUT default.
- One sub-module: edge_detect (1-bit registered rising-edge detector), instantiated per fx_done bit and once for sram_write_finish.

Test Plan:
- No effects, fx_enable=0, sample_in=16'h1234 → one sram write at offset 0 with data 16'h1234; sample_out=16'h1234 with a single-cycle valid; fx_my_turn stays 0.
- N_FX=2, both enabled, effect models return 16'h0AAA and 16'h0BBB → my_turn[0] then my_turn[1], never overlapping; RAM offset follows the granted model; sample_out=16'h0BBB.
- fx_enable=2'b10, smart_ram held sram_available=0 for 20 cycles → write delayed 20 cycles; only effect 1 granted; output equals effect 1 data.
- Effect 0 never asserts done, TIMEOUT=16 → grant drops after 16 cycles; fx_timeout=2'b01; effect 1 still runs; its data is output.
- Second sample_valid while busy → overrun=1 (sticky); second sample never written; first sample completes normally.
- rst pulsed during GRANT → fx_my_turn, sram_rd, sram_wr and busy go 0 without waiting for a clock edge; next sample_valid processed cleanly from IDLE.
